// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- multi-cycle datapath ALU (successor of the picoMIPS ALU)
//
// Single-cycle ops: pass-A, pass-B, add, subtract, AND, OR (code 7 = pass-A).
// Signed fixed-point multiply: iterative shift-add over N cycles on operand
// magnitudes, sign applied at the end, result = P >>> FRAC.
//
// Build option:
//   ALU_SATURATE_EN  defined   -> RADD/RSUB/RMULT clamp to the signed range
//                                 on overflow (ovf still reports 1).
//                    undefined -> results wrap to the low N bits.
//
// Parameters: N (operand width), FRAC (fractional bits of the product),
//             FW (function code width).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   issue request, sampled only in IDLE
//   func       in   operation code, sampled with start
//   a, b       in   signed operands, sampled with start
//   result     out  registered result, held until the next completion
//   done       out  one-cycle pulse: result/zero/ovf were just updated
//   busy       out  high while a multiply iterates
//   zero       out  result == 0, registered with result
//   ovf        out  signed overflow of the last op, registered with result
//   dbg_state  out  current FSM state (0 = IDLE, 1 = MUL)
//
// Handshake: start is a request accepted only while IDLE (busy=0); there is
// no queueing, a start seen while busy=1 is dropped. Every accepted request
// produces exactly one done pulse (1 cycle later for single-cycle ops, N+1
// cycles later for RMULT) unless reset intervenes. A start in the done cycle
// is accepted because the FSM is already back in IDLE.
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int N    = 8,
  parameter int FRAC = 7,
  parameter int FW   = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [FW-1:0] func,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic [N-1:0]  result,
  output logic          done,
  output logic          busy,
  output logic          zero,
  output logic          ovf,
  output logic          dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [FW-1:0] F_RA    = FW'(0);
  localparam logic [FW-1:0] F_RB    = FW'(1);
  localparam logic [FW-1:0] F_RADD  = FW'(2);
  localparam logic [FW-1:0] F_RSUB  = FW'(3);
  localparam logic [FW-1:0] F_RMULT = FW'(4);
  localparam logic [FW-1:0] F_RAND  = FW'(5);
  localparam logic [FW-1:0] F_ROR   = FW'(6);

`ifdef ALU_SATURATE_EN
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Multiply datapath registers
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_mcand;
  logic [N-1:0]   r_mplier;
  logic           r_sign;
  logic [2*N-1:0] r_acc;

  // Output registers
  logic [N-1:0]   r_result;
  logic           r_done;
  logic           r_zero;
  logic           r_ovf;

  // FSM decodes
  logic w_issue_single;
  logic w_issue_mul;
  logic w_mul_last;

  // ---------------------------------------------------------------------
  // Single-cycle ALU
  // ---------------------------------------------------------------------
  logic [N-1:0] w_sum;
  logic [N-1:0] w_diff;
  logic         w_add_ovf;
  logic         w_sub_ovf;
  logic [N-1:0] w_alu_res;
  logic         w_alu_ovf;

  assign w_sum     = a + b;
  assign w_diff    = a - b;
  // Overflow: operand signs agree (b inverted for sub) but result sign differs.
  assign w_add_ovf = (a[N-1] == b[N-1]) && (w_sum[N-1]  != a[N-1]);
  assign w_sub_ovf = (a[N-1] != b[N-1]) && (w_diff[N-1] != a[N-1]);

  always_comb begin : alu_comb
    w_alu_res = a;
    w_alu_ovf = 1'b0;
    case (func)
      F_RA:   w_alu_res = a;
      F_RB:   w_alu_res = b;
      F_RADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = w_add_ovf;
`ifdef ALU_SATURATE_EN
        // On overflow the true sum has the sign of the operands.
        if (w_add_ovf) w_alu_res = a[N-1] ? MIN_NEG : MAX_POS;
`endif
      end
      F_RSUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = w_sub_ovf;
`ifdef ALU_SATURATE_EN
        // On overflow the true difference has the sign of a.
        if (w_sub_ovf) w_alu_res = a[N-1] ? MIN_NEG : MAX_POS;
`endif
      end
      F_RAND: w_alu_res = a & b;
      F_ROR:  w_alu_res = a | b;
      default: w_alu_res = a;
    endcase
  end

  // ---------------------------------------------------------------------
  // Iterative multiply
  // ---------------------------------------------------------------------
  // Magnitudes are N-bit unsigned so |-2^(N-1)| = 2^(N-1) is representable.
  logic [N-1:0]   w_abs_a;
  logic [N-1:0]   w_abs_b;
  logic [2*N-1:0] w_partial;
  logic [2*N-1:0] w_acc_next;
  logic [2*N-1:0] w_prod;
  logic [2*N-1:0] w_shift;
  logic           w_mul_ovf;
  logic [N-1:0]   w_mul_res;

  assign w_abs_a    = a[N-1] ? -a : a;
  assign w_abs_b    = b[N-1] ? -b : b;
  assign w_partial  = r_mplier[r_cnt] ? ({{N{1'b0}}, r_mcand} << r_cnt) : '0;
  assign w_acc_next = r_acc + w_partial;
  // Max magnitude is 2^(2N-2), so the signed 2N-bit product cannot overflow.
  assign w_prod     = r_sign ? -w_acc_next : w_acc_next;
  assign w_shift    = (2*N)'($signed(w_prod) >>> FRAC);
  // In range iff all bits from N-1 upward are copies of the sign bit.
  assign w_mul_ovf  = !((&w_shift[2*N-1:N-1]) || (~|w_shift[2*N-1:N-1]));

  always_comb begin : mul_res_comb
    w_mul_res = w_shift[N-1:0];
`ifdef ALU_SATURATE_EN
    if (w_mul_ovf) w_mul_res = w_prod[2*N-1] ? MIN_NEG : MAX_POS;
`endif
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin : fsm_state_reg
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin : fsm_next
    w_state_next   = r_state;
    w_issue_single = 1'b0;
    w_issue_mul    = 1'b0;
    w_mul_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (func == F_RMULT) begin
            w_issue_mul  = 1'b1;
            w_state_next = S_MUL;
          end else begin
            w_issue_single = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_cnt == CW'(N-1)) begin
          w_mul_last   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin : dp_regs
    if (reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_issue_single) begin
        r_result <= w_alu_res;
        r_zero   <= (w_alu_res == '0);
        r_ovf    <= w_alu_ovf;
        r_done   <= 1'b1;
      end

      if (w_issue_mul) begin
        r_mcand  <= w_abs_a;
        r_mplier <= w_abs_b;
        r_sign   <= a[N-1] ^ b[N-1];
        r_acc    <= '0;
        r_cnt    <= '0;
      end

      if (r_state == S_MUL) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_mul_last) begin
        r_cnt    <= '0;
        r_result <= w_mul_res;
        r_zero   <= (w_mul_res == '0);
        r_ovf    <= w_mul_ovf;
        r_done   <= 1'b1;
      end
    end
  end

  assign result    = r_result;
  assign done      = r_done;
  assign busy      = (r_state == S_MUL);
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule
